mem_tester: RTL and testbench
=============================

# mem_tester

Built-in self-test controller that drives the 256x8 single-port-write / registered-read memory through a full write-then-verify pass. It writes a selectable data pattern to every address, reads every address back, compares each word against the expected value, and reports a pass/fail verdict, an error count and the first failing address. It sits between the board-level control (switches/buttons) and the memory instance. It owns the memory's `we`/`wra`/`wrd`/`rda` inputs and consumes its `rdd` output.

## Interface
- ADDR_W, 8, memory address width; depth is 2^ADDR_W
- DATA_W, 8, memory word width
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a test pass; sampled only in IDLE or DONE
- pattern  in  2  pattern select; latched when start is accepted
- mem_we  out  1  memory write enable
- mem_wra  out  ADDR_W  memory write address
- mem_wrd  out  DATA_W  memory write data
- mem_rda  out  ADDR_W  memory read address
- mem_rdd  in  DATA_W  memory read data; valid one cycle after mem_rda is presented
- busy  out  1  high in WRITE, READ and DRAIN
- done  out  1  high in DONE
- pass  out  1  done && err_count == 0
- err_count  out  ADDR_W+1  number of mismatching words, range 0..256
- first_err_addr  out  ADDR_W  address of the first mismatch; 0 if none

## Operation
- The block has five states: IDLE, WRITE, READ, DRAIN and DONE.
- IDLE / DONE: when start=1, the block latches pattern, clears err_count and first_err_addr, sets addr=0 and moves to WRITE. In DONE, the results hold until that next start.
- WRITE: mem_we=1, mem_wra=addr, mem_wrd=pat(addr), and addr increments each cycle. After addr=2^ADDR_W-1 is written, addr wraps to 0 and the block moves to READ.
- READ: mem_rda=addr and addr increments each cycle. A check pipeline stage (chk_valid, chk_addr) records each issued address. After the last address is issued, the block moves to DRAIN.
- DRAIN: one cycle that performs the final compare. The block then moves to DONE.
- Compare: on the cycle after an address is issued, chk_valid=1. If mem_rdd != pat(chk_addr), err_count increments. If this is the first error, first_err_addr <= chk_addr.
- Pattern function pat(a) is selected by the latched pattern:
  - 0: a
  - 1: ~a
  - 2: a[0] ? 8'hAA : 8'h55
  - 3: nibble swap {a[3:0], a[7:4]}
- Outside WRITE, mem_we=0, mem_wra=0 and mem_wrd=0. The block never reads and writes in the same cycle.
- A start pulse during busy is ignored.
- Reset mid-operation: the block returns to IDLE with all outputs at their reset values and the pass aborted. mem_we falls in the same edge.
- err_count is ADDR_W+1 bits wide, so it cannot overflow: the maximum is 256.

## Timing
- All outputs are registered.
- Reset values: mem_we=0, mem_wra=0, mem_wrd=0, mem_rda=0, busy=0, done=0, pass=0, err_count=0, first_err_addr=0.
- start sampled at edge k gives the following sequence:
  - WRITE during cycles k+1..k+256
  - READ during cycles k+257..k+512
  - DRAIN at k+513
  - done=1 from k+514
  - busy=1 for exactly 513 cycles.
- Read latency assumption: mem_rda presented in cycle c gives mem_rdd valid in cycle c+1. The compare happens at the end of c+1.
- pass and done rise together. Both fall on the edge that accepts the next start.

## Structure
- The shared package mem_test_pkg holds:
  - the state enum (IDLE, WRITE, READ, DRAIN, DONE)
  - the pattern codes PAT_ADDR, PAT_INV, PAT_CHECKER, PAT_NSWAP
  - the DEPTH constant
- One combinational sub-module, mem_test_pattern (a, pattern -> data). It is instantiated twice: once for write data and once for the expected value.

## Test plan
- Pattern 0 against the real memory block: start=1 for one cycle. Require done after 514 cycles, pass=1, err_count=0, and mem_wrd=8'h3C at wra=8'h3C.
- Stuck-at fault: use a behavioural memory with bit 0 of rdd forced to 1, pattern 1. Require err_count=128, first_err_addr=8'h01, pass=0.
- Single-word corruption: the bench overwrites address 8'hF7 with 8'h00 during READ before it is read, pattern 2. Require err_count=1, first_err_addr=8'hF7.
- Reset mid-WRITE at cycle k+100. Require mem_we=0 and state IDLE next cycle with all outputs at reset values. A following start gives a clean pass.
- start re-pulsed during READ is ignored; the total duration stays 513 busy cycles. start in DONE with pattern 3 clears the results and runs again, passing with mem_wrd=8'h21 at wra=8'h12.

Source files
------------

// File: rtl/mem_test_pkg.sv
// Shared types and constants for the memory self-test controller.
package mem_test_pkg;

  // Number of words in the memory under test.
  localparam int unsigned DEPTH = 256;

  // Controller states.
  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StDrain,
    StDone
  } state_e;

  // Data pattern select codes.
  localparam logic [1:0] PAT_ADDR    = 2'd0;
  localparam logic [1:0] PAT_INV     = 2'd1;
  localparam logic [1:0] PAT_CHECKER = 2'd2;
  localparam logic [1:0] PAT_NSWAP   = 2'd3;

endpackage

// File: rtl/mem_test_pattern.sv
// Combinational test-pattern generator: maps an address to its pattern word.
module mem_test_pattern
  import mem_test_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic [ADDR_W-1:0] a,
  input  logic [1:0]        pattern,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] a_ext;

  // Select the pattern word for the given address.
  always_comb begin
    data  = '0;
    a_ext = DATA_W'(a);
    case (pattern)
      PAT_ADDR:    data = a_ext;
      PAT_INV:     data = ~a_ext;
      PAT_CHECKER: data = a[0] ? {(DATA_W/2){2'b10}} : {(DATA_W/2){2'b01}};
      PAT_NSWAP:   data = {a_ext[DATA_W/2-1:0], a_ext[DATA_W-1:DATA_W/2]};
      default:     data = '0;
    endcase
  end

endmodule

// File: rtl/mem_tester.sv
// Memory BIST controller: writes a pattern to every address, reads it all back,
// and reports an error count, the first failing address and a pass verdict.
module mem_tester
  import mem_test_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        pattern,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_wra,
  output logic [DATA_W-1:0] mem_wrd,
  output logic [ADDR_W-1:0] mem_rda,
  input  logic [DATA_W-1:0] mem_rdd,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam logic [ADDR_W-1:0] LastAddr = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        pat_q, pat_d;
  logic              chk_valid_q, chk_valid_d;
  logic [ADDR_W-1:0] chk_addr_q, chk_addr_d;
  logic [ADDR_W:0]   err_q, err_d;
  logic [ADDR_W-1:0] first_q, first_d;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] wra_q, wra_d;
  logic [DATA_W-1:0] wrd_q, wrd_d;
  logic [ADDR_W-1:0] rda_q, rda_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] exp_data;

  // Write data is computed for the next cycle's address so mem_wrd can be registered.
  mem_test_pattern #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wr_pat (
    .a       (addr_d),
    .pattern (pat_d),
    .data    (wr_data)
  );

  // Expected read data for the address issued in the previous cycle.
  mem_test_pattern #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_exp_pat (
    .a       (chk_addr_q),
    .pattern (pat_q),
    .data    (exp_data)
  );

  // Next-state logic: sequencing, compare stage and registered output values.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pat_d       = pat_q;
    err_d       = err_q;
    first_d     = first_q;
    chk_valid_d = (state_q == StRead);
    chk_addr_d  = addr_q;

    // Read data arrives one cycle after the address, so compare against the chk stage.
    if (chk_valid_q && (mem_rdd != exp_data)) begin
      err_d = err_q + (ADDR_W+1)'(1);
      if (err_q == '0) begin
        first_d = chk_addr_q;
      end
    end

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StWrite;
          pat_d   = pattern;
          addr_d  = '0;
          err_d   = '0;
          first_d = '0;
        end
      end
      StWrite: begin
        addr_d = addr_q + ADDR_W'(1);
        if (addr_q == LastAddr) begin
          state_d = StRead;
        end
      end
      StRead: begin
        addr_d = addr_q + ADDR_W'(1);
        if (addr_q == LastAddr) begin
          state_d = StDrain;
        end
      end
      StDrain: state_d = StDone;
      default: state_d = StIdle;
    endcase

    we_d   = (state_d == StWrite);
    wra_d  = we_d ? addr_d : '0;
    wrd_d  = we_d ? wr_data : '0;
    rda_d  = (state_d == StRead) ? addr_d : '0;
    busy_d = state_d inside {StWrite, StRead, StDrain};
    done_d = (state_d == StDone);
    pass_d = done_d && (err_d == '0);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      pat_q       <= PAT_ADDR;
      chk_valid_q <= 1'b0;
      chk_addr_q  <= '0;
      err_q       <= '0;
      first_q     <= '0;
      we_q        <= 1'b0;
      wra_q       <= '0;
      wrd_q       <= '0;
      rda_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pat_q       <= pat_d;
      chk_valid_q <= chk_valid_d;
      chk_addr_q  <= chk_addr_d;
      err_q       <= err_d;
      first_q     <= first_d;
      we_q        <= we_d;
      wra_q       <= wra_d;
      wrd_q       <= wrd_d;
      rda_q       <= rda_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign mem_we         = we_q;
  assign mem_wra        = wra_q;
  assign mem_wrd        = wrd_q;
  assign mem_rda        = rda_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;

endmodule

// File: tb/tb_mem_tester.sv
// Self-checking bench for mem_tester with a behavioural 256x8 registered-read memory.
module tb_mem_tester;
  import mem_test_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] pattern;
  logic       mem_we;
  logic [7:0] mem_wra;
  logic [7:0] mem_wrd;
  logic [7:0] mem_rda;
  logic [7:0] mem_rdd;
  logic       busy;
  logic       done;
  logic       pass;
  logic [8:0] err_count;
  logic [7:0] first_err_addr;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int err;
    int first;
    bit pass;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  mem_tester #(
    .ADDR_W (8),
    .DATA_W (8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .pattern        (pattern),
    .mem_we         (mem_we),
    .mem_wra        (mem_wra),
    .mem_wrd        (mem_wrd),
    .mem_rda        (mem_rda),
    .mem_rdd        (mem_rdd),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

  // Behavioural memory with optional stuck-at-1 on bit 0 and a one-word corruption hook.
  logic [7:0] mem [DEPTH];
  logic [7:0] rdd_q;
  logic       stuck = 1'b0;
  logic       corrupt_req = 1'b0;

  always @(posedge clock) begin
    if (mem_we) mem[mem_wra] <= mem_wrd;
    if (corrupt_req) mem[8'hF7] <= 8'h00;
    rdd_q <= mem[mem_rda];
  end

  assign mem_rdd = stuck ? (rdd_q | 8'h01) : rdd_q;

  function automatic logic [7:0] pat_model(input logic [1:0] p, input logic [7:0] a);
    case (p)
      2'd0:    return a;
      2'd1:    return ~a;
      2'd2:    return a[0] ? 8'hAA : 8'h55;
      default: return {a[3:0], a[7:4]};
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_we"},    32'(mem_we), 0);
    check_eq({tag, "_wra"},   32'(mem_wra), 0);
    check_eq({tag, "_wrd"},   32'(mem_wrd), 0);
    check_eq({tag, "_rda"},   32'(mem_rda), 0);
    check_eq({tag, "_busy"},  32'(busy), 0);
    check_eq({tag, "_done"},  32'(done), 0);
    check_eq({tag, "_pass"},  32'(pass), 0);
    check_eq({tag, "_err"},   32'(err_count), 0);
    check_eq({tag, "_first"}, 32'(first_err_addr), 0);
    check_eq({tag, "_state"}, 32'(dut.state_q), 32'(StIdle));
  endtask

  // One full pass: model expected results, push them, run, then pop and compare.
  task automatic run_test(input logic [1:0] p, input bit st, input bit cor, input bit repulse,
                          input logic [7:0] mark);
    exp_t e;
    exp_t got_e;
    logic [7:0] rd;
    int cyc;
    int busy_n;
    bit seen;
    bit cor_done;
    e.err = 0;
    e.first = 0;
    for (int a = 0; a < DEPTH; a++) begin
      rd = pat_model(p, 8'(a));
      if (st) rd = rd | 8'h01;
      if (cor && a == 247) rd = 8'h00;
      if (rd != pat_model(p, 8'(a))) begin
        if (e.err == 0) e.first = a;
        e.err++;
      end
    end
    e.pass = (e.err == 0);
    sb.push_back(e);

    stuck   = st;
    pattern = p;
    start   = 1'b1;
    @(posedge clock);
    #1;
    start   = 1'b0;
    pattern = ~p;  // DUT must use the latched value
    check_eq("clr_err",  32'(err_count), 0);
    check_eq("clr_first", 32'(first_err_addr), 0);
    check_eq("clr_done", 32'(done), 0);
    check_eq("busy_on",  32'(busy), 1);

    cyc = 0;
    busy_n = 0;
    seen = 0;
    cor_done = 0;
    while (!done && cyc < 2000) begin
      if (busy) busy_n++;
      if (mem_we && mem_wra == mark) begin
        seen = 1;
        check_eq("wrd_mark", 32'(mem_wrd), 32'(pat_model(p, mark)));
      end
      corrupt_req = 1'b0;
      if (cor && !cor_done && busy && !mem_we) begin
        corrupt_req = 1'b1;
        cor_done = 1;
      end
      start = (repulse && cyc == 300);
      @(posedge clock);
      #1;
      cyc++;
    end
    start = 1'b0;
    corrupt_req = 1'b0;

    check_eq("wrd_seen", 32'(seen), 1);
    check_eq("done_latency", 32'(cyc + 1), 514);
    check_eq("busy_cycles", 32'(busy_n), 513);
    got_e = sb.pop_front();
    check_eq("err_count", 32'(err_count), 32'(got_e.err));
    check_eq("first_err", 32'(first_err_addr), 32'(got_e.first));
    check_eq("pass", 32'(pass), 32'(got_e.pass));
    check_eq("done", 32'(done), 1);
    @(posedge clock);
    #1;
    check_eq("done_hold", 32'(done), 1);
    check_eq("err_hold", 32'(err_count), 32'(got_e.err));
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    pattern = 2'd0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Clean pass, address pattern.
    run_test(2'd0, 1'b0, 1'b0, 1'b0, 8'h3C);
    // Bit 0 stuck high with the inverted pattern.
    run_test(2'd1, 1'b1, 1'b0, 1'b0, 8'h80);
    // Single-word corruption, checkerboard; started from DONE after a failing pass.
    run_test(2'd2, 1'b0, 1'b1, 1'b0, 8'hF7);

    // Reset during WRITE at cycle k+100.
    pattern = 2'd0;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (98) @(posedge clock);
    #1;
    check_eq("pre_rst_we", 32'(mem_we), 1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_reset_outputs("midrst");
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Clean pass after the abort, then a re-pulse during READ.
    run_test(2'd0, 1'b0, 1'b0, 1'b0, 8'h3C);
    run_test(2'd1, 1'b0, 1'b0, 1'b1, 8'h00);
    // Restart from DONE with nibble swap.
    run_test(2'd3, 1'b0, 1'b0, 1'b0, 8'h12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
